// File: rtl/dmem_io.sv
// dmem_io: data RAM plus memory-mapped CYCLE counter, LED register, TX FIFO and STATUS/done flags.
module dmem_io #(
  parameter int RAM_WORDS  = 64,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [31:0] a,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic [7:0]  led,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        done
);
  localparam int AW = $clog2(RAM_WORDS);
  localparam int PW = $clog2(FIFO_DEPTH);
  logic [31:0]   mem [RAM_WORDS];
  logic [7:0]    fifo_q [FIFO_DEPTH];
  logic [31:0]   cyc_q, cyc_d;
  logic [7:0]    led_q;
  logic [3:0]    cnt_q, cnt_d;
  logic [PW-1:0] wp_q, rp_q;
  logic          ovf_q, ovf_d, done_q, done_d;
  logic [29:0]   wa;
  logic          ram_sel, push_req, pop, push, full, empty;
  logic [31:0]   status;
  logic          unused_bits;
  assign wa          = a[31:2];
  assign unused_bits = ^a[1:0];
  assign ram_sel     = a[31:8] == 24'h0;
  assign full        = cnt_q == 4'(FIFO_DEPTH);
  assign empty       = cnt_q == 4'd0;
  assign status      = {24'h0, done_q, ovf_q, full, empty, cnt_q};
  assign led         = led_q;
  assign tx_valid    = !empty;
  assign tx_data     = fifo_q[rp_q];
  assign done        = done_q;
  always_comb begin
    cyc_d    = cyc_q + 32'd1;
    push_req = we && wa == 30'h42;
    pop      = tx_valid && tx_ready;
    push     = push_req && (!full || pop);
    cnt_d    = cnt_q + 4'(push) - 4'(pop);
    ovf_d    = (push_req && !push) ? 1'b1 : (we && wa == 30'h43) ? 1'b0 : ovf_q;
    done_d   = done_q || (we && wa == 30'h19 && wd == 32'd7);
    rd       = ram_sel        ? mem[a[AW+1:2]] :
               wa == 30'h40   ? cyc_q :
               wa == 30'h41   ? {24'h0, led_q} :
               wa == 30'h43   ? status : 32'h0;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cyc_q  <= '0;
      led_q  <= '0;
      cnt_q  <= '0;
      wp_q   <= '0;
      rp_q   <= '0;
      ovf_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      cyc_q  <= cyc_d;
      led_q  <= (we && wa == 30'h41) ? wd[7:0] : led_q;
      cnt_q  <= cnt_d;
      wp_q   <= wp_q + PW'(push);
      rp_q   <= rp_q + PW'(pop);
      ovf_q  <= ovf_d;
      done_q <= done_d;
    end
  end
  // Storage arrays carry no reset; only pointers/count define what is valid.
  always_ff @(posedge clk) begin
    if (we && ram_sel) mem[a[AW+1:2]] <= wd;
    if (push) fifo_q[wp_q] <= wd[7:0];
  end
endmodule

// File: doc/dmem_io.md
DMEM_IO -- requirements
Module: dmem_io

Interface
REQ-001 Parameter RAM_WORDS, default 64, gives the number of 32-bit data RAM words at byte addresses 0x000-0x0FF.
REQ-002 Parameter FIFO_DEPTH, default 4, gives the TX FIFO depth in entries; the value SHALL be a power of two, 2..8.
REQ-003 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 Port we, input, 1 bit: store strobe from the core (MemWrite).
REQ-006 Port a, input, 32 bits: byte address (DataAdr); a[1:0] SHALL be ignored (word access only).
REQ-007 Port wd, input, 32 bits: store data (WriteData).
REQ-008 Port rd, output, 32 bits: load data (ReadData), combinational from a.
REQ-009 Port led, output, 8 bits: LED register contents.
REQ-010 Port tx_data, output, 8 bits: TX FIFO head byte.
REQ-011 Port tx_valid, output, 1 bit: FIFO non-empty.
REQ-012 Port tx_ready, input, 1 bit: consumer accepts the head byte this cycle.
REQ-013 Port done, output, 1 bit: sticky simulation-success flag.

Function
REQ-014 Address map, decoded on a[31:2]: 0x000-0x0FF RAM; 0x100 CYCLE (read-only); 0x104 LED (read/write, bits 7:0); 0x108 TXDATA (write-only); 0x10C STATUS.
REQ-015 RAM: a write SHALL occur at the clock edge when we=1 and a is in 0x000-0x0FF; a read SHALL return RAM[a[7:2]] combinationally with no wait state.
REQ-016 CYCLE: a 32-bit counter SHALL increment by 1 on every clock edge after reset and wrap from 0xFFFFFFFF to 0. A read returns the pre-edge value. Writes are ignored.
REQ-017 LED: a write with we=1 SHALL load wd[7:0] at the edge. A read returns {24'b0, led}.
REQ-018 TXDATA: a push is a write with we=1. The push SHALL be accepted when the FIFO is not full, or when it is full and a pop occurs in the same cycle. A read returns 0.
REQ-019 Pop SHALL occur when tx_valid=1 and tx_ready=1. A simultaneous push and pop SHALL leave count unchanged and keep FIFO order.
REQ-020 tx_valid SHALL equal (count != 0). tx_data SHALL equal the head entry, registered storage, with no combinational path from wd.
REQ-021 A push that is not accepted SHALL set the sticky overflow flag and SHALL leave the FIFO contents unchanged.
REQ-022 tx_ready=1 while the FIFO is empty SHALL have no effect.
REQ-023 STATUS read layout: [3:0] count (0..FIFO_DEPTH), [4] empty, [5] full, [6] overflow, [7] done, [31:8] 0.
REQ-024 A write with we=1 to STATUS SHALL clear overflow only. done is unaffected.
REQ-025 done SHALL set at the edge where we=1, a=0x064 and wd=32'd7. It SHALL remain 1 until reset.
REQ-026 Reads of unmapped addresses (0x110 and above) SHALL return 0. Writes to them SHALL be ignored.
REQ-027 FIFO read and write pointers SHALL wrap modulo FIFO_DEPTH.

Reset
REQ-028 While reset=1, asynchronously: CYCLE=0, led=0, count=0, pointers=0, overflow=0, done=0, tx_valid=0.
REQ-029 RAM and FIFO storage contents are not reset.
REQ-030 Reset asserted mid-transfer SHALL discard all queued FIFO bytes. tx_valid SHALL drop in the same cycle reset asserts.

Verification
REQ-031 Release reset, wait 10 edges, read 0x100 -> 10. Force CYCLE to 0xFFFFFFFF, one edge -> reads 0.
REQ-032 Write 0xDEADBEEF to 0x040 then read 0x040 -> 0xDEADBEEF. Write 0x12345678 to 0x104 -> led=0x78 and a read of 0x104 returns 0x00000078.
REQ-033 tx_ready=0; push 0x11, 0x22, 0x33, 0x44, 0x55 -> STATUS=0x00000064 (count 4, full, overflow) and tx_data=0x11. Then tx_ready=1 for 4 cycles -> bytes 0x11, 0x22, 0x33, 0x44 in order, and STATUS=0x00000050 (empty, overflow still set).
REQ-034 Fill FIFO to 4, then in one cycle push 0x99 with tx_ready=1 -> count stays 4, overflow stays 0, and 0x99 emerges last.
REQ-035 Write 7 to 0x064 -> done=1 at the next edge. Write 6 to 0x064 or 7 to 0x068 in a fresh run -> done stays 0. Write to STATUS -> overflow clears and done stays 1.
REQ-036 Push 2 bytes, assert reset for 1 cycle mid-stream -> tx_valid=0 immediately and STATUS=0x00000010 after release.
